// File: rtl/dma_timing_control_if.sv
// Bus bundle for dma_timing_control: request/grant handshake, programming port
// and the address/strobe/status outputs.
interface dma_timing_control_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic [3:0]        DREQ;
  logic              HLDA;
  logic [3:0]        DACK;
  logic              PROG_WE;
  logic [1:0]        PROG_CH;
  logic [ADDR_W-1:0] PROG_ADDR;
  logic [CNT_W-1:0]  PROG_COUNT;

  logic              HRQ;
  logic              assertDACK;
  logic              AEN;
  logic [ADDR_W-1:0] ADDR;
  logic              MEMR_N;
  logic              IOW_N;
  logic              EOP;
  logic [3:0]        TC;
  logic [3:0]        MASK;

  modport master (
    output DREQ, HLDA, DACK, PROG_WE, PROG_CH, PROG_ADDR, PROG_COUNT,
    input  HRQ, assertDACK, AEN, ADDR, MEMR_N, IOW_N, EOP, TC, MASK
  );

  modport slave (
    input  DREQ, HLDA, DACK, PROG_WE, PROG_CH, PROG_ADDR, PROG_COUNT,
    output HRQ, assertDACK, AEN, ADDR, MEMR_N, IOW_N, EOP, TC, MASK
  );
endinterface

// File: rtl/dma_timing_control.sv
// Four-channel DMA timing controller: hold handshake, grant latch and the
// S1..S4 transfer cycle with per-channel address/count/terminal-count state.
module dma_timing_control #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  dma_timing_control_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HOLD, S1, S2, S3, S4} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addrReg [4];
  logic [CNT_W-1:0]  cntReg  [4];
  logic [1:0]        actCh;
  logic              hldaLost;
  logic [3:0]        tcReg;
  logic [3:0]        maskReg;

  logic              hrq;
  logic              dackEn;
  logic              aen;
  logic [ADDR_W-1:0] addrOut;
  logic              memrN;
  logic              iowN;
  logic              eop;

  logic              eligible;
  logic              dackValid;
  logic [1:0]        dackIdx;
  logic              progBlocked;
  logic              tcHit;

  always_comb begin
    eligible  = |(bus.DREQ & ~maskReg);
    dackValid = (bus.DACK != '0) && ((bus.DACK & (bus.DACK - 4'd1)) == '0);
    dackIdx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bus.DACK[i]) dackIdx = 2'(i);
    end
    // In S1 the channel about to be latched is already the active one.
    progBlocked = 1'b0;
    case (state)
      S1:         progBlocked = dackValid && (dackIdx == bus.PROG_CH);
      S2, S3, S4: progBlocked = (actCh == bus.PROG_CH);
      default:    progBlocked = 1'b0;
    endcase
    tcHit = (state == S3) && (cntReg[actCh] == '0);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      actCh    <= '0;
      hldaLost <= 1'b0;
      hrq      <= 1'b0;
      dackEn   <= 1'b0;
      aen      <= 1'b0;
      addrOut  <= '0;
      memrN    <= 1'b1;
      iowN     <= 1'b1;
      eop      <= 1'b0;
      tcReg    <= '0;
      maskReg  <= '1;
      for (int unsigned i = 0; i < 4; i++) begin
        addrReg[i] <= '0;
        cntReg[i]  <= '0;
      end
    end else begin
      eop <= 1'b0;

      if (bus.PROG_WE && !progBlocked) begin
        addrReg[bus.PROG_CH] <= bus.PROG_ADDR;
        cntReg[bus.PROG_CH]  <= bus.PROG_COUNT;
        tcReg[bus.PROG_CH]   <= 1'b0;
        maskReg[bus.PROG_CH] <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (eligible) begin
            state <= HOLD;
            hrq   <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.HLDA) begin
            state    <= S1;
            dackEn   <= 1'b1;
            hldaLost <= 1'b0;
          end else if (!eligible) begin
            state <= IDLE;
            hrq   <= 1'b0;
          end
        end
        S1: begin
          dackEn   <= 1'b0;
          hldaLost <= hldaLost | ~bus.HLDA;
          if (dackValid) begin
            state   <= S2;
            actCh   <= dackIdx;
            aen     <= 1'b1;
            addrOut <= addrReg[dackIdx];
            memrN   <= 1'b0;
            iowN    <= 1'b0;
          end else begin
            state <= IDLE;
            hrq   <= 1'b0;
          end
        end
        S2: begin
          state    <= S3;
          hldaLost <= hldaLost | ~bus.HLDA;
        end
        S3: begin
          // Address/count advance on S4 entry; ADDR keeps showing the word just moved.
          state          <= S4;
          hldaLost       <= hldaLost | ~bus.HLDA;
          memrN          <= 1'b1;
          iowN           <= 1'b1;
          addrReg[actCh] <= addrReg[actCh] + ADDR_W'(1);
          cntReg[actCh]  <= cntReg[actCh] - CNT_W'(1);
          if (tcHit) begin
            eop            <= 1'b1;
            tcReg[actCh]   <= 1'b1;
            maskReg[actCh] <= 1'b1;
          end
        end
        S4: begin
          aen     <= 1'b0;
          addrOut <= '0;
          if (bus.HLDA && !hldaLost && eligible) begin
            state  <= S1;
            dackEn <= 1'b1;
          end else begin
            state <= IDLE;
            hrq   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          hrq    <= 1'b0;
          dackEn <= 1'b0;
          aen    <= 1'b0;
          memrN  <= 1'b1;
          iowN   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.HRQ        = hrq;
  assign bus.assertDACK = dackEn;
  assign bus.AEN        = aen;
  assign bus.ADDR       = addrOut;
  assign bus.MEMR_N     = memrN;
  assign bus.IOW_N      = iowN;
  assign bus.EOP        = eop;
  assign bus.TC         = tcReg;
  assign bus.MASK       = maskReg;

endmodule
